// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants and the sequencer state encoding.
package vga_timing_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int CNT_W     = 10;

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // IDLE: stopped, outputs inactive. ARM: enabled, waiting for first pixel tick.
  // RUN: raster advancing on each pixel tick.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: position counter with wrap at TOTAL-1, plus registered
// active-low sync decode. The visible decode is exported for the next count
// so the top can register it alongside the counter.
module vga_axis_cnt #(
  parameter int VISIBLE = 640,
  parameter int FRONT   = 16,
  parameter int SYNC    = 96,
  parameter int BACK    = 48,
  parameter int CNT_W   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             sync_n,
  output logic             vis_nxt
);

  localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(VISIBLE + FRONT);
  localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(VISIBLE + FRONT + SYNC);
  localparam logic [CNT_W-1:0] VIS_END = CNT_W'(VISIBLE);

  logic [CNT_W-1:0] cnt_nxt;

  assign wrap = adv && (cnt == LAST);

  // Next count: clear wins, otherwise step or wrap on advance.
  always_comb begin
    cnt_nxt = cnt;
    if (clr)
      cnt_nxt = '0;
    else if (adv)
      cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;
    vis_nxt = !clr && (cnt_nxt < VIS_END);
  end

  // Counter and sync decode share one edge so they never skew.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      sync_n <= 1'b1;
    end else begin
      cnt    <= cnt_nxt;
      sync_n <= clr || !((cnt_nxt >= SYNC_LO) && (cnt_nxt < SYNC_HI));
    end
  end

endmodule

// File: rtl/vga_sync_ctrl.sv
// VGA raster sequencer: IDLE/ARM/RUN control around horizontal and vertical
// axis counters, advanced by the pixel tick.
// Optional feature macro VGA_SYNC_FRAME_CNT_EN adds a 16-bit frame counter port.
module vga_sync_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK,
  parameter int CNT_W     = vga_timing_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  input  logic             en,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             frame_start,
`ifdef VGA_SYNC_FRAME_CNT_EN
  output logic [15:0]      frame_cnt,
`endif
  output logic             busy
);

  state_t state, state_nxt;
  logic   clr, h_adv, h_wrap, v_wrap;
  logic   h_vis_nxt, v_vis_nxt, fs_nxt;

  // Next-state and per-cycle advance decode; en low always wins over pix_en.
  always_comb begin
    state_nxt = state;
    fs_nxt    = 1'b0;
    h_adv     = 1'b0;
    case (state)
      IDLE: if (en) state_nxt = ARM;
      ARM: begin
        if (!en)
          state_nxt = IDLE;
        else if (pix_en) begin
          state_nxt = RUN;
          fs_nxt    = 1'b1;
        end
      end
      RUN: begin
        if (!en)
          state_nxt = IDLE;
        else
          h_adv = pix_en;
      end
      default: state_nxt = IDLE;
    endcase
    clr = (state_nxt != RUN);
    if (v_wrap)
      fs_nxt = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  vga_axis_cnt #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .CNT_W(CNT_W)
  ) u_h (
    .clk(clk), .rst(rst), .clr(clr), .adv(h_adv),
    .cnt(pixel_x), .wrap(h_wrap), .sync_n(hsync), .vis_nxt(h_vis_nxt)
  );

  vga_axis_cnt #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .CNT_W(CNT_W)
  ) u_v (
    .clk(clk), .rst(rst), .clr(clr), .adv(h_wrap),
    .cnt(pixel_y), .wrap(v_wrap), .sync_n(vsync), .vis_nxt(v_vis_nxt)
  );

  // Registered video_on and frame_start, aligned with the counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      video_on    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      video_on    <= h_vis_nxt && v_vis_nxt;
      frame_start <= fs_nxt;
    end
  end

  assign busy = (state == RUN);

`ifdef VGA_SYNC_FRAME_CNT_EN
  // Frame counter: counts frame_start pulses, cleared whenever IDLE is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      frame_cnt <= '0;
    else if ((state != IDLE) && (state_nxt == IDLE))
      frame_cnt <= '0;
    else if (fs_nxt)
      frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Scoreboard bench for vga_sync_ctrl using a reduced raster so several full
// frames fit in a short run. The reference tracks the raster as a linear tick
// index within the frame and derives x/y/sync/visible arithmetically.
module tb_vga_sync_ctrl;

  localparam int HV = 16, HF = 4, HS = 6, HB = 4;
  localparam int VV = 10, VF = 2, VS = 2, VB = 3;
  localparam int W  = 10;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pix_en = 1'b0;
  logic         en = 1'b0;
  logic         hsync, vsync, video_on, frame_start, busy;
  logic [W-1:0] pixel_x, pixel_y;
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [15:0]  frame_cnt;
`endif

  vga_sync_ctrl #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .CNT_W(W)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .en(en),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start),
`ifdef VGA_SYNC_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   x, y, fc;
    logic hs, vs, von, fs, bsy;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference: mode 0 stopped, 1 waiting for first tick, 2 rastering; t = tick index in frame.
  int mode = 0;
  int t = 0;
  int fcnt = 0;

  function automatic int cur_x();
    return (mode == 2) ? t % HT : 0;
  endfunction

  task automatic cycle(input logic e, input logic p, input logic r);
    exp_t ex;
    logic fs;
    int   prev_mode;
    int   x, y;
    @(negedge clk);
    #1;
    en = e; pix_en = p; rst = r;
    fs = 1'b0;
    prev_mode = mode;
    if (r) begin
      mode = 0; t = 0; fcnt = 0;
      #1;
      vectors++;
      if (pixel_x !== '0 || pixel_y !== '0 || hsync !== 1'b1 || vsync !== 1'b1 ||
          video_on !== 1'b0 || frame_start !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL async_reset: got x=%0d y=%0d hs=%b vs=%b von=%b fs=%b busy=%b, expected all idle values",
                 pixel_x, pixel_y, hsync, vsync, video_on, frame_start, busy);
      end
    end else begin
      case (mode)
        0: if (e) mode = 1;
        1: if (!e) mode = 0;
           else if (p) begin mode = 2; t = 0; fs = 1'b1; end
        default: if (!e) begin mode = 0; t = 0; end
                 else if (p) begin t = (t + 1) % FT; fs = (t == 0); end
      endcase
      if (fs) fcnt = (fcnt + 1) % 65536;
      if (prev_mode != 0 && mode == 0) fcnt = 0;
    end
    x = cur_x();
    y = (mode == 2) ? t / HT : 0;
    ex.x   = x;
    ex.y   = y;
    ex.fc  = fcnt;
    ex.hs  = !(mode == 2 && x >= HV + HF && x < HV + HF + HS);
    ex.vs  = !(mode == 2 && y >= VV + VF && y < VV + VF + VS);
    ex.von = (mode == 2) && (x < HV) && (y < VV);
    ex.fs  = fs;
    ex.bsy = (mode == 2);
    q.push_back(ex);
  endtask

  // Monitor: compares each registered result one half-cycle after its edge.
  always @(negedge clk) begin
    exp_t e;
    logic bad;
    if (q.size() > 0) begin
      e = q.pop_front();
      bad = (int'(pixel_x) != e.x) || (int'(pixel_y) != e.y) || (hsync !== e.hs) ||
            (vsync !== e.vs) || (video_on !== e.von) || (frame_start !== e.fs) ||
            (busy !== e.bsy);
`ifdef VGA_SYNC_FRAME_CNT_EN
      if (int'(frame_cnt) != e.fc) bad = 1'b1;
`endif
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL raster vec%0d: got x=%0d y=%0d hs=%b vs=%b von=%b fs=%b busy=%b, expected x=%0d y=%0d hs=%b vs=%b von=%b fs=%b busy=%b fc=%0d",
                 vectors, pixel_x, pixel_y, hsync, vsync, video_on, frame_start, busy,
                 e.x, e.y, e.hs, e.vs, e.von, e.fs, e.bsy, e.fc);
      end
    end
  end

  initial begin
    int budget;
    repeat (3) cycle(1'b0, 1'b0, 1'b1);
    repeat (5) cycle(1'b0, 1'b0, 1'b0);
    // pix_en every 4th clock: first tick starts the raster.
    for (int i = 0; i < 60; i++) cycle(1'b1, (i % 4) == 3, 1'b0);
    // Random tick density across several full frames.
    for (int i = 0; i < 3000; i++) cycle(1'b1, $urandom_range(0, 3) != 0, 1'b0);
    // Async reset mid-run, then release with en low: must stay idle.
    cycle(1'b1, 1'b1, 1'b1);
    repeat (6) cycle(1'b0, $urandom_range(0, 1) != 0, 1'b0);
    // Restart, then drop en on a tick while inside the hsync region.
    budget = 0;
    while (!(mode == 2 && cur_x() == HV + HF + 2) && budget < 5000) begin
      cycle(1'b1, $urandom_range(0, 1) != 0, 1'b0);
      budget++;
    end
    vectors++;
    if (budget >= 5000) begin
      miscompares++;
      $display("FAIL drop_en_setup: raster never reached x=%0d within %0d cycles", HV + HF + 2, budget);
    end
    cycle(1'b0, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 1200; i++) cycle(1'b1, $urandom_range(0, 2) != 0, 1'b0);
    // Occasional en drops at random raster positions.
    for (int i = 0; i < 1500; i++) cycle($urandom_range(0, 59) != 0, $urandom_range(0, 1) != 0, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected results left unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
